// File: rtl/i2s_play_ctrl.sv
// I2S playback controller: arbitrates two sample sources onto the TX FIFO
// write port and sequences the transmitter through IDLE/PREFILL/PLAY/DRAIN,
// aborting playback after a run of underrun frames.
module i2s_play_ctrl #(
    parameter int DEPTH          = 256,
    parameter int LEVEL_W        = 9,
    parameter int PREFILL        = 16,
    parameter int UNDERRUN_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               rr_mode,
    input  logic [15:0]        s0_data,
    input  logic               s0_valid,
    output logic               s0_ready,
    input  logic [15:0]        s1_data,
    input  logic               s1_valid,
    output logic               s1_ready,
    output logic               fifo_wr_en,
    output logic [15:0]        fifo_wr_data,
    output logic               fifo_flush,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               lrc,
    output logic               tx_run,
    output logic [1:0]         state,
    output logic [15:0]        underrun_cnt,
    output logic               err
);

    localparam int CNT_W = $clog2(UNDERRUN_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_PLAY    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state_q, state_d;
    logic             tx_run_q, tx_run_d;
    logic             wr_en_q, wr_en_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             flush_q, flush_d;
    logic [15:0]      ucnt_q, ucnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             rr_q, rr_d;       // 1: source 1 has priority on the next tie
    logic             lrc_q;

    logic             accepting;
    logic             room;
    logic [LEVEL_W:0] level_ext;
    logic             gnt0, gnt1, xfer;
    logic             frame_edge;
    logic [CNT_W-1:0] consec_inc;

    // Write grant: only while accepting samples and the FIFO has room for
    // one more beyond any write already in flight.
    always_comb begin
        accepting = (state_q == S_PREFILL) || (state_q == S_PLAY);
        level_ext = {1'b0, fifo_level} + {{LEVEL_W{1'b0}}, wr_en_q};
        room      = !fifo_full && (level_ext < (LEVEL_W + 1)'(DEPTH));
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (accepting && room) begin
            if (rr_mode && s0_valid && s1_valid) begin
                gnt0 = !rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = s0_valid;
                gnt1 = s1_valid && !s0_valid;
            end
        end
        xfer = (gnt0 && s0_valid) || (gnt1 && s1_valid);
    end

    // Sequencer next-state, underrun accounting and write-port pipeline.
    always_comb begin
        state_d    = state_q;
        tx_run_d   = tx_run_q;
        flush_d    = 1'b0;
        ucnt_d     = ucnt_q;
        err_d      = err_q;
        consec_d   = consec_q;
        frame_edge = lrc && !lrc_q;
        consec_inc = consec_q + CNT_W'(1);
        rr_d       = xfer ? gnt0 : rr_q;
        wr_en_d    = xfer;
        wr_data_d  = xfer ? (gnt0 ? s0_data : s1_data) : wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d  = S_PREFILL;
                    err_d    = 1'b0;
                    ucnt_d   = 16'd0;
                    consec_d = '0;
                end
            end
            S_PREFILL: begin
                if (stop) begin
                    state_d = S_IDLE;
                    flush_d = 1'b1;
                end else if (fifo_level >= LEVEL_W'(PREFILL)) begin
                    state_d  = S_PLAY;
                    tx_run_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (frame_edge) begin
                    if (fifo_empty) begin
                        ucnt_d   = sat_inc16(ucnt_q);
                        consec_d = consec_inc;
                    end else begin
                        consec_d = '0;
                    end
                end
                if (frame_edge && fifo_empty && (consec_inc >= CNT_W'(UNDERRUN_LIMIT))) begin
                    state_d  = S_IDLE;
                    tx_run_d = 1'b0;
                    err_d    = 1'b1;
                    flush_d  = 1'b1;
                end else if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_edge && fifo_empty && !wr_en_q) begin
                    state_d  = S_IDLE;
                    tx_run_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A write still in flight when the FIFO is cleared is discarded.
        if (flush_d) begin
            wr_en_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_run_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 16'd0;
            flush_q   <= 1'b0;
            ucnt_q    <= 16'd0;
            err_q     <= 1'b0;
            consec_q  <= '0;
            rr_q      <= 1'b0;
            lrc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_run_q  <= tx_run_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            flush_q   <= flush_d;
            ucnt_q    <= ucnt_d;
            err_q     <= err_d;
            consec_q  <= consec_d;
            rr_q      <= rr_d;
            lrc_q     <= lrc;
        end
    end

    assign s0_ready     = gnt0;
    assign s1_ready     = gnt1;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_flush   = flush_q;
    assign tx_run       = tx_run_q;
    assign state        = state_q;
    assign underrun_cnt = ucnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_i2s_play_ctrl.sv
// Testbench for i2s_play_ctrl: FIFO model, scoreboarded write port,
// randomized arbitration traffic and directed sequencer scenarios.
module tb_i2s_play_ctrl;

    localparam int DEPTH   = 256;
    localparam int LEVEL_W = 9;
    localparam int PREFILL = 16;
    localparam int LIMIT   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0, stop = 1'b0, rr_mode = 1'b0;
    logic [15:0]        s0_data = '0, s1_data = '0;
    logic               s0_valid = 1'b0, s1_valid = 1'b0;
    logic               s0_ready, s1_ready;
    logic               fifo_wr_en, fifo_flush;
    logic [15:0]        fifo_wr_data;
    logic               fifo_full = 1'b0, fifo_empty = 1'b1;
    logic [LEVEL_W-1:0] fifo_level = '0;
    logic               lrc = 1'b0;
    logic               tx_run, err;
    logic [1:0]         state;
    logic [15:0]        underrun_cnt;

    i2s_play_ctrl #(
        .DEPTH(DEPTH), .LEVEL_W(LEVEL_W), .PREFILL(PREFILL), .UNDERRUN_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .rr_mode(rr_mode),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_flush(fifo_flush),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .lrc(lrc), .tx_run(tx_run), .state(state), .underrun_cnt(underrun_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int dut_hs = 0;
    int wr_cnt = 0;
    int flush_cnt = 0;

    logic [15:0] sb[$];     // expected FIFO writes, in order
    logic [15:0] fq[$];     // contents of the modelled TX FIFO
    bit pop_en  = 1'b0;     // serializer consuming one sample per cycle
    bit pri     = 1'b0;     // round-robin: source that wins the next tie
    bit exp_pend = 1'b0;    // a write is expected in flight
    bit exp_acc = 1'b0;     // controller expected to accept samples

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // External TX FIFO: absorbs writes, clears on flush, drains when enabled.
    always @(posedge clk) begin
        if (fifo_flush) begin
            fq.delete();
        end else begin
            if (fifo_wr_en) begin
                vectors++;
                if (fq.size() >= DEPTH) begin
                    miscompares++;
                    $display("FAIL fifo_overflow: write with %0d stored, capacity %0d", fq.size(), DEPTH);
                end else begin
                    fq.push_back(fifo_wr_data);
                end
            end
            if (pop_en && fq.size() > 0) void'(fq.pop_front());
        end
        fifo_level <= LEVEL_W'(fq.size());
        fifo_full  <= (fq.size() >= DEPTH);
        fifo_empty <= (fq.size() == 0);
    end

    // Write-port monitor: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst) begin
            if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) dut_hs++;
            if (fifo_flush) flush_cnt++;
            if (fifo_wr_en) begin
                wr_cnt++;
                vectors++;
                if (fifo_flush) begin
                    miscompares++;
                    $display("FAIL wr_with_flush: fifo_wr_en=1 while fifo_flush=1, required 0");
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: data 0x%0h written, no write required", fifo_wr_data);
                end else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    if (fifo_wr_data !== e) begin
                        miscompares++;
                        $display("FAIL wr_data: got 0x%0h, expected 0x%0h", fifo_wr_data, e);
                    end
                end
            end
        end
    end

    // One clock of stimulus, issued just after a falling edge.
    task automatic step(input bit v0, input bit v1, input logic [15:0] d0, input logic [15:0] d1,
                        input bit st, input bit sp, input bit l);
        bit room, g0, g1;
        int winner;
        s0_valid = v0; s1_valid = v1; s0_data = d0; s1_data = d1;
        start = st; stop = sp; lrc = l;
        #1;
        room = (fq.size() + (exp_pend ? 1 : 0)) < DEPTH;
        g0 = 1'b0; g1 = 1'b0;
        if (exp_acc && room && (v0 || v1)) begin
            if (v0 && v1) winner = rr_mode ? int'(pri) : 0;
            else          winner = v0 ? 0 : 1;
            g0 = (winner == 0);
            g1 = (winner == 1);
        end
        chk("s0_ready", s0_ready, g0);
        chk("s1_ready", s1_ready, g1);
        if (g0 || g1) begin
            sb.push_back(g0 ? d0 : d1);
            pri = g0;
        end
        exp_pend = g0 || g1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 0, 0, 0);
    endtask

    task automatic do_start();
        int lvl;
        step(0, 0, 16'h0, 16'h0, 1, 0, 0);
        exp_acc = 1'b1;
        chk("start_state", state, 1);
        chk("start_err", err, 0);
        chk("start_ucnt", underrun_cnt, 0);
        for (int i = 0; i < 64; i++) begin
            lvl = fq.size();
            step(1, 0, 16'($urandom), 16'h0, 0, 0, 0);
            if (lvl >= PREFILL) begin
                chk("prefill_to_play", state, 2);
                chk("prefill_tx_run", tx_run, 1);
                return;
            end
            chk("prefill_state", state, 1);
            chk("prefill_tx_run_off", tx_run, 0);
        end
        vectors++; miscompares++;
        $display("FAIL prefill_timeout: state=%0d after 64 cycles, required 2", state);
    endtask

    task automatic drain_fifo();
        pop_en = 1'b1;
        for (int i = 0; i < 300 && fq.size() > 0; i++) idle(1);
        pop_en = 1'b0;
    endtask

    task automatic frame_edge();
        step(0, 0, 16'h0, 16'h0, 0, 0, 1);
    endtask

    task automatic frame_low();
        step(0, 0, 16'h0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        int f0;
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_tx_run", tx_run, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        idle(2);
        chk("idle_no_start", state, 0);

        // Prefill, then randomized two-source traffic in PLAY.
        do_start();
        for (int i = 0; i < 300; i++) begin
            if (i % 30 == 0) rr_mode = 1'($urandom);
            pop_en = 1'($urandom);
            step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0);
        end
        chk("random_state", state, 2);

        // Both sources saturated: alternate in round-robin, s0 only when fixed.
        pop_en = 1'b1;
        rr_mode = 1'b1;
        for (int i = 0; i < 12; i++) step(1, 1, 16'hAAAA, 16'h5555, 0, 0, 0);
        rr_mode = 1'b0;
        for (int i = 0; i < 8; i++) step(1, 1, 16'hAAAA, 16'h5555, 0, 0, 0);

        // Backpressure: fill the FIFO to capacity with s0 streaming.
        pop_en = 1'b0;
        for (int i = 0; i < 300; i++) step(1, 1'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0);
        chk("bp_full_flag", fifo_full, 1);
        chk("bp_fill", fq.size(), DEPTH);

        // Stop in PLAY and drain back to IDLE.
        step(0, 0, 16'h0, 16'h0, 0, 1, 0);
        exp_acc = 1'b0;
        chk("stop_to_drain", state, 3);
        drain_fifo();
        chk("drain_hold", tx_run, 1);
        frame_edge();
        chk("drain_done_state", state, 0);
        chk("drain_done_tx", tx_run, 0);
        frame_low();

        // Underrun abort after LIMIT consecutive empty frames.
        do_start();
        idle(2);
        drain_fifo();
        for (int k = 1; k <= LIMIT; k++) begin
            f0 = flush_cnt;
            frame_edge();
            chk("ur_count", underrun_cnt, k);
            if (k < LIMIT) begin
                chk("ur_state", state, 2);
                chk("ur_err", err, 0);
                frame_low();
            end else begin
                exp_acc = 1'b0;
                chk("abort_state", state, 0);
                chk("abort_tx", tx_run, 0);
                chk("abort_err", err, 1);
                frame_low();
                frame_low();
                chk("abort_flush_pulses", flush_cnt - f0, 1);
            end
        end

        // Non-empty frame resets the consecutive run.
        do_start();
        idle(2);
        drain_fifo();
        for (int k = 0; k < 3; k++) begin frame_edge(); frame_low(); end
        step(1, 0, 16'h1234, 16'h0, 0, 0, 0);
        idle(2);
        frame_edge(); frame_low();
        drain_fifo();
        for (int k = 0; k < 3; k++) begin frame_edge(); frame_low(); end
        chk("ur_pattern_cnt", underrun_cnt, 6);
        chk("ur_pattern_state", state, 2);
        chk("ur_pattern_err", err, 0);

        // Asynchronous reset mid-PLAY takes effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_tx", tx_run, 0);
        chk("arst_ucnt", underrun_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        pri = 1'b0; exp_pend = 1'b0; exp_acc = 1'b0;

        // start and stop together in IDLE.
        step(0, 0, 16'h0, 16'h0, 1, 1, 0);
        chk("start_stop_idle", state, 0);

        // stop during PREFILL flushes.
        step(0, 0, 16'h0, 16'h0, 1, 0, 0);
        exp_acc = 1'b1;
        chk("pf_state", state, 1);
        f0 = flush_cnt;
        step(0, 0, 16'h0, 16'h0, 0, 1, 0);
        exp_acc = 1'b0;
        chk("pf_stop_state", state, 0);
        idle(1);
        chk("pf_stop_flush", flush_cnt - f0, 1);

        // Drain with five samples queued.
        do_start();
        idle(2);
        pop_en = 1'b1;
        for (int i = 0; i < 300 && fq.size() > 5; i++) idle(1);
        pop_en = 1'b0;
        chk("drain_queued", fq.size(), 5);
        step(0, 0, 16'h0, 16'h0, 0, 1, 0);
        exp_acc = 1'b0;
        chk("d5_state", state, 3);
        for (int i = 0; i < 3; i++) step(1, 1, 16'($urandom), 16'($urandom), 0, 0, 0);
        frame_edge(); frame_low();
        chk("d5_nonempty_edge", state, 3);
        chk("d5_nonempty_tx", tx_run, 1);
        drain_fifo();
        f0 = flush_cnt;
        frame_edge();
        chk("d5_done_state", state, 0);
        chk("d5_done_tx", tx_run, 0);
        chk("d5_no_underrun", underrun_cnt, 0);
        frame_low(); idle(1);
        chk("d5_no_flush", flush_cnt - f0, 0);

        chk("handshakes_vs_writes", wr_cnt, dut_hs);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
